regfile_arbiter: RTL
====================

Name: regfile_arbiter

Overview:
Shares the 16x16-bit register file between two requesters: the core pipeline (core_*) and an auxiliary loader/debug port (aux_*). Each cycle it grants at most one requester the use of both read ports and the write port. It drives the regfile address, data and write-enable lines, and returns registered read data one cycle after acceptance. It also blocks writes to R15, which is the PC alias.

Parameters:
PRIORITY_MODE, 0, 0 = round-robin; 1 = core fixed priority with an aux starvation guard.
MAX_WAIT, 8, the number of consecutive cycles aux may be refused before it is forced; must be >= 1.
CNT_W, 4, width of the starvation counter; must satisfy 2**CNT_W > MAX_WAIT.

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high.
core_valid / aux_valid  in  1  request present.
core_we / aux_we  in  1  request includes a write.
core_ra1, core_ra2 / aux_ra1, aux_ra2  in  4  read addresses.
core_wa / aux_wa  in  4  write address.
core_wd / aux_wd  in  16  write data.
core_ready / aux_ready  out  1  request accepted this cycle.
core_rvalid / aux_rvalid  out  1  response valid (one cycle after accept).
core_rd1, core_rd2 / aux_rd1, aux_rd2  out  16  registered read data.
core_err / aux_err  out  1  accompanies rvalid; 1 = write to R15 rejected.
rf_we  out  1  regfile write enable.
rf_a1, rf_a2, rf_a3  out  4  regfile read/write addresses.
rf_wd3  out  16  regfile write data.
rf_rd1, rf_rd2  in  16  regfile combinational read data.
grant_owner  out  1  0 = core, 1 = aux; meaningful only while a ready is high.

Behaviour:
- Acceptance: a request is accepted when valid && ready. Ready is combinational from the valids and the arbitration state. At most one ready is high per cycle.
- Address muxing: rf_a1, rf_a2 and rf_a3 follow the granted requester. When nothing is granted, all rf_* outputs are 0.
- Write timing: on acceptance with we=1 and wa != 15, rf_we=1 and rf_wd3=wd in the same cycle, so the regfile writes on that clock edge.
- R15 write: on acceptance with we=1 and wa == 15, rf_we=0; the request is still accepted, and err=1 in the response.
- Read response: rf_rd1/rf_rd2 are sampled at the accept edge. The next cycle, the owner's rvalid=1 and rd1/rd2 hold the sampled values. rvalid is a 1-cycle pulse.
- Read-after-write: a read of the same address in the same accepted request returns the old value.
- R15 reads are allowed and return the PC via the regfile.
- Round-robin mode (PRIORITY_MODE=0):
  - A sole valid requester is granted.
  - If both are valid, the requester that was not granted last wins.
  - last_grant updates only on acceptance.
- Priority mode (PRIORITY_MODE=1):
  - Core wins ties.
  - wait_cnt increments each cycle that aux_valid && !aux_ready, saturating at MAX_WAIT.
  - When wait_cnt == MAX_WAIT, aux wins the next tie; wait_cnt clears when aux is accepted or when aux_valid drops.
- Reset: on the cycle reset is sampled:
  - all ready, rvalid, rd, err and rf_* outputs are 0;
  - last_grant = aux, so core wins the first round-robin tie;
  - wait_cnt = 0.
- Reset mid-operation: a response pending from the previous accept is discarded, so rvalid stays 0.
- Requesters may drop valid at any time without penalty. Requests that are not accepted have no side effects.

Optional Feature:
REGFILE_ARB_LOCK_EN:
- Enabled: adds core_lock and aux_lock inputs (1 bit each). If the owner is accepted with lock=1, it keeps exclusive grant on following cycles while its valid && lock remain high. The other requester's ready is forced to 0 during that time. The starvation force is suppressed while locked, but wait_cnt keeps counting.
- Disabled: the lock ports are absent and there is no locking.

Decomposition:
- Package regfile_pkg:
  - constants ADDR_W=4, DATA_W=16, NUM_REGS=16, PC_REG=4'd15;
  - typedef rf_req_t (valid, we, ra1, ra2, wa, wd);
  - typedef enum owner_e {OWN_CORE, OWN_AUX}.
- One sub-module, rr_arbiter2: holds the two-way grant logic, last_grant register and starvation counter. The top level does the muxing and response registering.

Test Plan:
1. Core-only write, wa=3, wd=9 -> core_ready=1 in the same cycle with rf_we=1, rf_a3=3, rf_wd3=9. Next cycle core_rvalid=1, core_err=0.
2. After writes R3=9 and R6=5, core reads ra1=3, ra2=6 -> the cycle after accept, core_rd1=9 and core_rd2=5.
3. PRIORITY_MODE=0, both valid continuously after reset -> grant order core, aux, core, aux; never two readys in one cycle.
4. PRIORITY_MODE=1, MAX_WAIT=4, both valid continuously -> core granted for 4 cycles, aux granted on the 5th, then wait_cnt=0 and core again.
5. aux write wa=15, wd=16'hBEEF -> aux_ready=1 and rf_we=0. Next cycle aux_rvalid=1, aux_err=1. With PC=4, a read of ra2=15 returns rd2=4.
6. Reset asserted the cycle after a core accept -> core_rvalid=0 and all rf_* outputs 0. The first tie after reset is granted to core.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the 16x16 register file and its two-port arbiter.
package regfile_pkg;

  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 16;
  localparam logic [ADDR_W-1:0] PC_REG = ADDR_W'(NUM_REGS - 1);

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
  } rf_req_t;

  typedef enum logic {OWN_CORE = 1'b0, OWN_AUX = 1'b1} owner_e;

  // R15 aliases the PC, so a write aimed at it never reaches the regfile.
  function automatic logic is_rf_write(input rf_req_t r);
    return r.valid && r.we && (r.wa != PC_REG);
  endfunction

endpackage

// File: rtl/regfile_arbiter_rr_arbiter2.sv
// Two-way grant logic (round-robin or core-priority with aux starvation guard); grants are
// combinational from the valids. Optional grant locking under `REGFILE_ARB_LOCK_EN.
module rr_arbiter2
  import regfile_pkg::*;
#(
  parameter int PRIORITY_MODE = 0,
  parameter int MAX_WAIT      = 8,
  parameter int CNT_W         = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   core_valid_i,
  input  logic   aux_valid_i,
`ifdef REGFILE_ARB_LOCK_EN
  input  logic   core_lock_i,
  input  logic   aux_lock_i,
`endif
  output logic   core_gnt_o,
  output logic   aux_gnt_o,
  output owner_e owner_o
);

  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  owner_e           last_grant_q, last_grant_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             starved;
  logic             aux_wins_tie;

`ifdef REGFILE_ARB_LOCK_EN
  logic   locked_q, locked_d;
  owner_e lock_owner_q, lock_owner_d;
  logic   lock_hold;
`endif

  always_comb begin
    core_gnt_o   = 1'b0;
    aux_gnt_o    = 1'b0;
    starved      = (wait_cnt_q == WAIT_MAX);
    if (PRIORITY_MODE == 0) aux_wins_tie = (last_grant_q == OWN_CORE);
    else                    aux_wins_tie = starved;
`ifdef REGFILE_ARB_LOCK_EN
    // A held lock overrides both round-robin order and the starvation force.
    lock_hold = locked_q && ((lock_owner_q == OWN_CORE) ? (core_valid_i && core_lock_i)
                                                        : (aux_valid_i && aux_lock_i));
    if (lock_hold) aux_wins_tie = (lock_owner_q == OWN_AUX);
`endif
    if (!reset) begin
      if (core_valid_i && aux_valid_i) begin
        aux_gnt_o  = aux_wins_tie;
        core_gnt_o = !aux_wins_tie;
      end else begin
        core_gnt_o = core_valid_i;
        aux_gnt_o  = aux_valid_i;
      end
    end
    owner_o = aux_gnt_o ? OWN_AUX : OWN_CORE;

    last_grant_d = last_grant_q;
    if (core_gnt_o)     last_grant_d = OWN_CORE;
    else if (aux_gnt_o) last_grant_d = OWN_AUX;

    wait_cnt_d = wait_cnt_q;
    if (!aux_valid_i || aux_gnt_o) wait_cnt_d = '0;
    else if (!starved)             wait_cnt_d = wait_cnt_q + 1'b1;

`ifdef REGFILE_ARB_LOCK_EN
    locked_d     = (core_gnt_o && core_lock_i) || (aux_gnt_o && aux_lock_i);
    lock_owner_d = owner_o;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= OWN_AUX;
      wait_cnt_q   <= '0;
`ifdef REGFILE_ARB_LOCK_EN
      locked_q     <= 1'b0;
      lock_owner_q <= OWN_CORE;
`endif
    end else begin
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
`ifdef REGFILE_ARB_LOCK_EN
      locked_q     <= locked_d;
      lock_owner_q <= lock_owner_d;
`endif
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares the regfile between core and aux: same-cycle accept/write, read data one cycle later.
// Blocks R15 writes; `REGFILE_ARB_LOCK_EN adds core_lock/aux_lock grant locking.
module regfile_arbiter
  import regfile_pkg::*;
#(
  parameter int PRIORITY_MODE = 0,
  parameter int MAX_WAIT      = 8,
  parameter int CNT_W         = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_valid,
  input  logic              aux_valid,
`ifdef REGFILE_ARB_LOCK_EN
  input  logic              core_lock,
  input  logic              aux_lock,
`endif
  input  logic              core_we,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] core_ra1,
  input  logic [ADDR_W-1:0] core_ra2,
  input  logic [ADDR_W-1:0] aux_ra1,
  input  logic [ADDR_W-1:0] aux_ra2,
  input  logic [ADDR_W-1:0] core_wa,
  input  logic [ADDR_W-1:0] aux_wa,
  input  logic [DATA_W-1:0] core_wd,
  input  logic [DATA_W-1:0] aux_wd,
  output logic              core_ready,
  output logic              aux_ready,
  output logic              core_rvalid,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] core_rd1,
  output logic [DATA_W-1:0] core_rd2,
  output logic [DATA_W-1:0] aux_rd1,
  output logic [DATA_W-1:0] aux_rd2,
  output logic              core_err,
  output logic              aux_err,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_a1,
  output logic [ADDR_W-1:0] rf_a2,
  output logic [ADDR_W-1:0] rf_a3,
  output logic [DATA_W-1:0] rf_wd3,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic              grant_owner
);

  rf_req_t core_req, aux_req, sel_req;
  logic    core_gnt, aux_gnt;
  owner_e  owner;

  logic              rvalid_q, rvalid_d;
  owner_e            rsp_owner_q, rsp_owner_d;
  logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
  logic              err_q, err_d;
  logic              core_rsp, aux_rsp;

  assign core_req = '{valid: core_valid, we: core_we, ra1: core_ra1, ra2: core_ra2,
                      wa: core_wa, wd: core_wd};
  assign aux_req  = '{valid: aux_valid, we: aux_we, ra1: aux_ra1, ra2: aux_ra2,
                      wa: aux_wa, wd: aux_wd};

  rr_arbiter2 #(
    .PRIORITY_MODE (PRIORITY_MODE),
    .MAX_WAIT      (MAX_WAIT),
    .CNT_W         (CNT_W)
  ) u_arb (
    .clk          (clk),
    .reset        (reset),
    .core_valid_i (core_valid),
    .aux_valid_i  (aux_valid),
`ifdef REGFILE_ARB_LOCK_EN
    .core_lock_i  (core_lock),
    .aux_lock_i   (aux_lock),
`endif
    .core_gnt_o   (core_gnt),
    .aux_gnt_o    (aux_gnt),
    .owner_o      (owner)
  );

  assign core_ready  = core_gnt;
  assign aux_ready   = aux_gnt;
  assign grant_owner = (owner == OWN_AUX);

  // An all-zero selected request means nothing granted, which zeroes every rf_* output.
  always_comb begin
    sel_req = '0;
    if (core_gnt)     sel_req = core_req;
    else if (aux_gnt) sel_req = aux_req;

    rf_a1  = sel_req.ra1;
    rf_a2  = sel_req.ra2;
    rf_a3  = sel_req.wa;
    rf_wd3 = sel_req.wd;
    rf_we  = is_rf_write(sel_req);

    rvalid_d    = sel_req.valid;
    rsp_owner_d = owner;
    rd1_d       = sel_req.valid ? rf_rd1 : rd1_q;
    rd2_d       = sel_req.valid ? rf_rd2 : rd2_q;
    err_d       = sel_req.valid && sel_req.we && (sel_req.wa == PC_REG);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q    <= 1'b0;
      rsp_owner_q <= OWN_CORE;
      rd1_q       <= '0;
      rd2_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      rvalid_q    <= rvalid_d;
      rsp_owner_q <= rsp_owner_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      err_q       <= err_d;
    end
  end

  // Gating with reset drops a response that was pending when reset arrived.
  assign core_rsp    = rvalid_q && !reset && (rsp_owner_q == OWN_CORE);
  assign aux_rsp     = rvalid_q && !reset && (rsp_owner_q == OWN_AUX);
  assign core_rvalid = core_rsp;
  assign aux_rvalid  = aux_rsp;
  assign core_rd1    = core_rsp ? rd1_q : '0;
  assign core_rd2    = core_rsp ? rd2_q : '0;
  assign aux_rd1     = aux_rsp ? rd1_q : '0;
  assign aux_rd2     = aux_rsp ? rd2_q : '0;
  assign core_err    = core_rsp && err_q;
  assign aux_err     = aux_rsp && err_q;

endmodule
